// File: rtl/data_mem_pkg.sv
// Shared FSM type and configuration limits for the data memory controller.
package data_mem_pkg;

    typedef enum logic [0:0] {
        MS_CLEAR = 1'b0,
        MS_IDLE  = 1'b1
    } mem_state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;
    localparam int unsigned DEPTH_MIN  = 2;

    function automatic logic cfg_ok(input int unsigned rd_lat, input int unsigned depth);
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX) && (depth >= DEPTH_MIN);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read response pipeline: RD_LAT stages of valid/data; each data stage only
// loads when its incoming valid is set, so the output holds between responses.
module mem_rd_pipe #(
    parameter int unsigned W      = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_vld [RD_LAT];
    logic [W-1:0] r_dat [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_vld[k] <= 1'b0;
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[RD_LAT-1];
    assign o_data  = r_dat[RD_LAT-1];

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with valid/ready requests, a registered read path and
// a clear engine that zeroes one word per cycle after reset and on request.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [W-1:0]  req_wdata,
    output logic          rsp_valid,
    output logic [W-1:0]  rsp_data,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    mem_state_t    r_state;
    mem_state_t    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic          w_ready_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_in_range;
    logic          w_accept;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_clr_we;
    logic [W-1:0]  w_rd_word;
    logic [W-1:0]  r_mem [DEPTH];

    if (!cfg_ok(RD_LAT, DEPTH)) begin : g_bad_cfg
        $error("data_mem_ctrl: RD_LAT must be 1..2 and DEPTH >= 2");
    end

    // Out-of-range writes are dropped, out-of-range reads return zero.
    assign w_in_range = (32'(req_addr) < DEPTH);
    assign w_accept   = req_valid && r_ready;
    assign w_wr_en    = w_accept && req_we && w_in_range;
    assign w_rd_en    = w_accept && !req_we;
    assign w_clr_we   = (r_state == MS_CLEAR);
    assign w_rd_word  = w_in_range ? r_mem[req_addr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MS_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            MS_CLEAR: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = MS_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            MS_IDLE: begin
                if (clear_start) begin
                    w_state_nxt = MS_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = MS_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
        w_ready_nxt = (w_state_nxt == MS_IDLE);
        w_busy_nxt  = (w_state_nxt == MS_CLEAR);
    end

    // Storage has no reset; the clear engine owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[req_addr] <= req_wdata;
        end
    end

    mem_rd_pipe #(
        .W      (W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .i_valid (w_rd_en),
        .i_data  (w_rd_word),
        .o_valid (rsp_valid),
        .o_data  (rsp_data)
    );

    assign req_ready  = r_ready;
    assign clear_busy = r_busy;
    assign clear_done = r_done;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three configurations (defaults, RD_LAT=2, DEPTH=200)
// share one stimulus stream and are checked against a per-instance reference model.
module tb_data_mem_ctrl;

    localparam int unsigned NI   = 3;
    localparam int unsigned MAXD = 256;

    logic clk = 1'b0;
    logic reset;
    logic req_valid;
    logic req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic clear_start;

    logic [NI-1:0]      req_ready;
    logic [NI-1:0]      rsp_valid;
    logic [NI-1:0]      clear_busy;
    logic [NI-1:0]      clear_done;
    logic [NI-1:0][7:0] rsp_data;

    // Reference model state
    logic [NI-1:0]      e_ready;
    logic [NI-1:0]      e_busy;
    logic [NI-1:0]      e_done;
    logic [NI-1:0]      e_rv;
    logic [NI-1:0][7:0] e_rd;
    bit [7:0] m_mem  [NI][MAXD];
    int       m_busy [NI];
    bit       m_done [NI];
    bit [7:0] m_last [NI];
    bit       pv     [NI][4];
    bit [7:0] pd     [NI][4];

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.W(8), .DEPTH(256), .RD_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .clear_start(clear_start),
        .clear_busy(clear_busy[0]), .clear_done(clear_done[0])
    );

    data_mem_ctrl #(.W(8), .DEPTH(256), .RD_LAT(2)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .clear_start(clear_start),
        .clear_busy(clear_busy[1]), .clear_done(clear_done[1])
    );

    data_mem_ctrl #(.W(8), .DEPTH(200), .RD_LAT(1)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .clear_start(clear_start),
        .clear_busy(clear_busy[2]), .clear_done(clear_done[2])
    );

    function automatic int depth_of(input int i);
        return (i == 2) ? 200 : 256;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = depth_of(i);
            m_done[i] = 1'b0;
            m_last[i] = 8'h00;
            for (int s = 0; s < 4; s++) pv[i][s] = 1'b0;
            for (int a = 0; a < MAXD; a++) m_mem[i][a] = 8'h00;
        end
        e_ready = '0;
        e_busy  = '1;
        e_done  = '0;
        e_rv    = '0;
        e_rd    = '0;
    endtask

    // One clock edge of the behavioural model: busy countdown, memory array,
    // and a small calendar of responses due at a given cycle number.
    function automatic void model_edge();
        for (int i = 0; i < NI; i++) begin
            bit rdy;
            int slot;
            rdy       = (m_busy[i] == 0);
            m_done[i] = 1'b0;
            if (rdy && req_valid) begin
                if (req_we) begin
                    if (int'(req_addr) < depth_of(i)) m_mem[i][req_addr] = req_wdata;
                end else begin
                    slot = (cyc + lat_of(i) - 1) % 4;
                    pv[i][slot] = 1'b1;
                    pd[i][slot] = (int'(req_addr) < depth_of(i)) ? m_mem[i][req_addr] : 8'h00;
                end
            end
            if (rdy && clear_start) begin
                m_busy[i] = depth_of(i);
                for (int a = 0; a < MAXD; a++) m_mem[i][a] = 8'h00;
            end else if (!rdy) begin
                m_busy[i] = m_busy[i] - 1;
                if (m_busy[i] == 0) m_done[i] = 1'b1;
            end
            slot = cyc % 4;
            e_rv[i] = pv[i][slot];
            if (pv[i][slot]) begin
                m_last[i]   = pd[i][slot];
                pv[i][slot] = 1'b0;
            end
            e_rd[i]    = m_last[i];
            e_ready[i] = (m_busy[i] == 0);
            e_busy[i]  = (m_busy[i] != 0);
            e_done[i]  = m_done[i];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic we, input logic [7:0] a,
                           input logic [7:0] d, input logic cs);
        req_valid   = v;
        req_we      = we;
        req_addr    = a;
        req_wdata   = d;
        clear_start = cs;
    endtask

    task automatic test_reset();
        set_req(0, 0, 8'h00, 8'h00, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, clear_busy, clear_done, rsp_valid} !== 12'b000_111_000_000) begin
            n_fail++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b rv=%b exp rdy=000 busy=111 done=000 rv=000",
                     req_ready, clear_busy, clear_done, rsp_valid);
        end
        n_checks++;
        if (rsp_data !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=000000", rsp_data);
        end
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_clear_after_reset();
        int busy0 = 0, busy2 = 0, done0 = 0, done2 = 0, done_at0 = -1, rdy_at0 = -1;
        for (int n = 0; n < 260; n++) begin
            if (clear_busy[0] === 1'b1) busy0++;
            if (clear_busy[2] === 1'b1) busy2++;
            if (clear_done[0] === 1'b1) begin done0++; done_at0 = n; end
            if (clear_done[2] === 1'b1) done2++;
            if (req_ready[0] === 1'b1 && rdy_at0 < 0) rdy_at0 = n;
            step();
            n_checks++;
            if ({req_ready, clear_busy, clear_done} !== {e_ready, e_busy, e_done}) begin
                n_fail++;
                $display("FAIL boot_clear ctrl cyc=%0d got rdy/busy/done=%b/%b/%b exp=%b/%b/%b",
                         cyc, req_ready, clear_busy, clear_done, e_ready, e_busy, e_done);
            end
        end
        n_checks++;
        if (busy0 != 256 || busy2 != 200) begin
            n_fail++;
            $display("FAIL boot_busy_len got inst0=%0d inst2=%0d exp 256/200", busy0, busy2);
        end
        n_checks++;
        if (done0 != 1 || done2 != 1 || rdy_at0 != done_at0) begin
            n_fail++;
            $display("FAIL boot_done got pulses=%0d/%0d done_at=%0d rdy_at=%0d exp 1/1 equal",
                     done0, done2, done_at0, rdy_at0);
        end
        set_req(1, 0, 8'h7F, 8'h00, 0);
        step();
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL boot_read7f got v=%b d=%h exp v=1 d=00", rsp_valid[0], rsp_data[0]);
        end
        set_req(0, 0, 8'h00, 8'h00, 0);
        for (int n = 0; n < 2; n++) begin
            step();
            n_checks++;
            if ({rsp_valid, rsp_data} !== {e_rv, e_rd}) begin
                n_fail++;
                $display("FAIL boot_read rsp cyc=%0d got v=%b d=%h exp v=%b d=%h",
                         cyc, rsp_valid, rsp_data, e_rv, e_rd);
            end
        end
    endtask

    task automatic test_write_read();
        for (int n = 0; n < 4; n++) begin
            case (n)
                0:       set_req(1, 1, 8'h10, 8'hA5, 0);
                1:       set_req(1, 0, 8'h10, 8'h00, 0);
                default: set_req(0, 0, 8'h00, 8'h00, 0);
            endcase
            step();
            n_checks++;
            if ({req_ready, clear_busy, clear_done, rsp_valid, rsp_data} !==
                {e_ready, e_busy, e_done, e_rv, e_rd}) begin
                n_fail++;
                $display("FAIL wr_rd cyc=%0d got rdy=%b busy=%b done=%b v=%b d=%h exp rdy=%b busy=%b done=%b v=%b d=%h",
                         cyc, req_ready, clear_busy, clear_done, rsp_valid, rsp_data,
                         e_ready, e_busy, e_done, e_rv, e_rd);
            end
            if (n == 1) begin
                n_checks++;
                if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'hA5 || rsp_valid[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_rd_lat1 got v0=%b d0=%h v1=%b exp v0=1 d0=a5 v1=0",
                             rsp_valid[0], rsp_data[0], rsp_valid[1]);
                end
            end
            if (n == 2) begin
                n_checks++;
                if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 8'hA5 || rsp_valid[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_rd_lat2 got v1=%b d1=%h v0=%b exp v1=1 d1=a5 v0=0",
                             rsp_valid[1], rsp_data[1], rsp_valid[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] vb1;
        logic [7:0] d1 [7];
        for (int n = 0; n < 4; n++) begin
            set_req(1, 1, 8'(8'h20 + n), 8'(n + 1), 0);
            step();
        end
        for (int j = 0; j < 7; j++) begin
            if (j < 4) set_req(1, 0, 8'(8'h20 + j), 8'h00, 0);
            else       set_req(0, 0, 8'h00, 8'h00, 0);
            step();
            n_checks++;
            if ({rsp_valid, rsp_data} !== {e_rv, e_rd}) begin
                n_fail++;
                $display("FAIL b2b rsp cyc=%0d got v=%b d=%h exp v=%b d=%h",
                         cyc, rsp_valid, rsp_data, e_rv, e_rd);
            end
            vb1[j] = rsp_valid[1];
            d1[j]  = rsp_data[1];
        end
        n_checks++;
        if (vb1 !== 7'b0011110 || {d1[1], d1[2], d1[3], d1[4]} !== 32'h01020304) begin
            n_fail++;
            $display("FAIL b2b_lat2 got valid=%b data=%h%h%h%h exp valid=0011110 data=01020304",
                     vb1, d1[1], d1[2], d1[3], d1[4]);
        end
    endtask

    task automatic test_clear_during_read();
        int rejected = 0;
        bit accepted = 1'b0;
        bit was_ready;
        set_req(1, 1, 8'hFF, 8'h3C, 0);
        step();
        set_req(1, 0, 8'hFF, 8'h00, 1);
        step();
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'h3C || clear_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_rd_pre got v=%b d=%h busy=%b exp v=1 d=3c busy=1",
                     rsp_valid[0], rsp_data[0], clear_busy[0]);
        end
        set_req(1, 0, 8'hFF, 8'h00, 0);
        for (int n = 0; n < 300 && !accepted; n++) begin
            if (req_ready[0] !== 1'b1) rejected++;
            was_ready = (m_busy[0] == 0);
            step();
            n_checks++;
            if ({req_ready, clear_busy, clear_done, rsp_valid, rsp_data} !==
                {e_ready, e_busy, e_done, e_rv, e_rd}) begin
                n_fail++;
                $display("FAIL clr_rd cyc=%0d got rdy=%b busy=%b done=%b v=%b d=%h exp rdy=%b busy=%b done=%b v=%b d=%h",
                         cyc, req_ready, clear_busy, clear_done, rsp_valid, rsp_data,
                         e_ready, e_busy, e_done, e_rv, e_rd);
            end
            if (was_ready) accepted = 1'b1;
        end
        n_checks++;
        if (!accepted || rejected != 256 || rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_rd_held got accepted=%0d stalled=%0d v=%b d=%h exp 1/256 v=1 d=00",
                     accepted, rejected, rsp_valid[0], rsp_data[0]);
        end
        set_req(0, 0, 8'h00, 8'h00, 0);
        repeat (2) step();
    endtask

    task automatic test_reset_mid_clear();
        int busy0 = 0, busy2 = 0;
        set_req(0, 0, 8'h00, 8'h00, 1);
        step();
        set_req(0, 0, 8'h00, 8'h00, 0);
        for (int n = 0; n < 100; n++) begin
            step();
            n_checks++;
            if ({req_ready, clear_busy, clear_done} !== {e_ready, e_busy, e_done}) begin
                n_fail++;
                $display("FAIL mid_clr ctrl cyc=%0d got rdy/busy/done=%b/%b/%b exp=%b/%b/%b",
                         cyc, req_ready, clear_busy, clear_done, e_ready, e_busy, e_done);
            end
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, clear_busy, clear_done, rsp_valid} !== 12'b000_111_000_000 || rsp_data !== 24'h0) begin
            n_fail++;
            $display("FAIL mid_clr_reset got rdy=%b busy=%b done=%b v=%b d=%h exp 000/111/000/000 d=000000",
                     req_ready, clear_busy, clear_done, rsp_valid, rsp_data);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 260; n++) begin
            if (clear_busy[0] === 1'b1) busy0++;
            if (clear_busy[2] === 1'b1) busy2++;
            step();
            n_checks++;
            if ({req_ready, clear_busy, clear_done} !== {e_ready, e_busy, e_done}) begin
                n_fail++;
                $display("FAIL mid_clr_restart cyc=%0d got rdy/busy/done=%b/%b/%b exp=%b/%b/%b",
                         cyc, req_ready, clear_busy, clear_done, e_ready, e_busy, e_done);
            end
        end
        n_checks++;
        if (busy0 != 256 || busy2 != 200) begin
            n_fail++;
            $display("FAIL mid_clr_busy_len got inst0=%0d inst2=%0d exp 256/200", busy0, busy2);
        end
    endtask

    task automatic test_out_of_range();
        for (int n = 0; n < 5; n++) begin
            case (n)
                0:       set_req(1, 1, 8'd210, 8'h55, 0);
                1:       set_req(1, 0, 8'd210, 8'h00, 0);
                2:       set_req(1, 1, 8'd199, 8'h66, 0);
                3:       set_req(1, 0, 8'd199, 8'h00, 0);
                default: set_req(0, 0, 8'h00, 8'h00, 0);
            endcase
            step();
            n_checks++;
            if ({rsp_valid, rsp_data} !== {e_rv, e_rd}) begin
                n_fail++;
                $display("FAIL oor rsp cyc=%0d got v=%b d=%h exp v=%b d=%h",
                         cyc, rsp_valid, rsp_data, e_rv, e_rd);
            end
            if (n == 1) begin
                n_checks++;
                if (rsp_valid[2] !== 1'b1 || rsp_data[2] !== 8'h00 || rsp_data[0] !== 8'h55) begin
                    n_fail++;
                    $display("FAIL oor_read210 got v2=%b d2=%h d0=%h exp v2=1 d2=00 d0=55",
                             rsp_valid[2], rsp_data[2], rsp_data[0]);
                end
            end
            if (n == 3) begin
                n_checks++;
                if (rsp_valid[2] !== 1'b1 || rsp_data[2] !== 8'h66) begin
                    n_fail++;
                    $display("FAIL oor_read199 got v2=%b d2=%h exp v2=1 d2=66", rsp_valid[2], rsp_data[2]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            set_req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(190, 255)),
                    8'($urandom), $urandom_range(0, 127) == 0);
            step();
            n_checks++;
            if ({req_ready, clear_busy, clear_done, rsp_valid, rsp_data} !==
                {e_ready, e_busy, e_done, e_rv, e_rd}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got rdy=%b busy=%b done=%b v=%b d=%h exp rdy=%b busy=%b done=%b v=%b d=%h",
                         cyc, req_ready, clear_busy, clear_done, rsp_valid, rsp_data,
                         e_ready, e_busy, e_done, e_rv, e_rd);
            end
        end
        set_req(0, 0, 8'h00, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_clear_after_reset();
        test_write_read();
        test_back_to_back();
        test_clear_during_read();
        test_reset_mid_clear();
        test_out_of_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
